alu_command_sequencer: RTL and testbench

Registered command front-end that drives the combinational ALU's input interface from the board's raw push-buttons and switches. It synchronizes and debounces the four active-low operation buttons, then captures the pressed button, mode switches and both operands into registers. It holds that command stable after the button is released, so the ALU result and flag displays stay valid. The block sits between the board I/O pins and the ALU instance in the top level.

---
 rtl/alu_command_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_command_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_command_sequencer.sv
// rtl/alu_command_sequencer.sv - debounced, latched command front-end for the ALU
module alu_command_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   buttons_n,
    input  logic [1:0]   mode_sw,
    input  logic [N-1:0] a_sw,
    input  logic [N-1:0] b_sw,
    output logic [N-1:0] A_num,
    output logic [N-1:0] B_num,
    output logic [3:0]   operations_buttons,
    output logic [1:0]   change_mode,
    output logic         cmd_valid,
    output logic         cmd_strobe
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Counter value on the edge before the last debounce edge; reaching it completes the count.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_REL     = 3'd3;
    localparam logic [2:0] ST_LATCHED = 3'd4;

    logic [3:0]       btn_q1, btn_s;
    logic [1:0]       mode_q1, mode_s;
    logic [N-1:0]     a_q1, a_s, b_q1, b_s;
    logic [2:0]       state;
    logic [3:0]       pend;
    logic [CNT_W-1:0] cnt;
    logic             from_latched;
    logic [3:0]       btn_inv;
    logic             btn_valid;
    logic             btn_idle;

    // Two-flop synchronizers for every asynchronous board input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q1  <= 4'b1111;
            btn_s   <= 4'b1111;
            mode_q1 <= '0;
            mode_s  <= '0;
            a_q1    <= '0;
            a_s     <= '0;
            b_q1    <= '0;
            b_s     <= '0;
        end else begin
            btn_q1  <= buttons_n;
            btn_s   <= btn_q1;
            mode_q1 <= mode_sw;
            mode_s  <= mode_q1;
            a_q1    <= a_sw;
            a_s     <= a_q1;
            b_q1    <= b_sw;
            b_s     <= b_q1;
        end
    end

    // Classify the synchronized button pattern: exactly one low bit is a valid command.
    always_comb begin
        btn_inv   = ~btn_s;
        btn_valid = (btn_inv != 4'd0) && ((btn_inv & (btn_inv - 4'd1)) == 4'd0);
        btn_idle  = (btn_s == 4'b1111);
    end

    // Debounce FSM with the command capture registers it controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            pend               <= 4'b1111;
            cnt                <= '0;
            from_latched       <= 1'b0;
            A_num              <= '0;
            B_num              <= '0;
            operations_buttons <= 4'b1111;
            change_mode        <= 2'b00;
            cmd_valid          <= 1'b0;
            cmd_strobe         <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            case (state)
                ST_IDLE, ST_LATCHED: begin
                    if (btn_valid) begin
                        pend         <= btn_s;
                        cnt          <= '0;
                        from_latched <= (state == ST_LATCHED);
                        state        <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (btn_s == pend) begin
                        if (cnt == CNT_LAST) begin
                            operations_buttons <= pend;
                            change_mode        <= mode_s;
                            A_num              <= a_s;
                            B_num              <= b_s;
                            cmd_valid          <= 1'b1;
                            cmd_strobe         <= 1'b1;
                            state              <= ST_HOLD;
                        end else if (cnt != CNT_SAT) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (btn_valid) begin
                        pend <= btn_s;
                        cnt  <= '0;
                    end else begin
                        // Abort leaves any earlier latched command untouched.
                        state <= from_latched ? ST_LATCHED : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (btn_idle) begin
                        cnt   <= '0;
                        state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!btn_idle) begin
                        state <= ST_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LATCHED;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_command_sequencer.sv
// tb/tb_alu_command_sequencer.sv - scoreboard bench for alu_command_sequencer
module tb_alu_command_sequencer;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   buttons_n;
    logic [1:0]   mode_sw;
    logic [N-1:0] a_sw, b_sw;
    logic [N-1:0] A_num, B_num;
    logic [3:0]   operations_buttons;
    logic [1:0]   change_mode;
    logic         cmd_valid, cmd_strobe;

    typedef struct packed {
        logic [3:0]   ops;
        logic [1:0]   mode;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;

    alu_command_sequencer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .buttons_n          (buttons_n),
        .mode_sw            (mode_sw),
        .a_sw               (a_sw),
        .b_sw               (b_sw),
        .A_num              (A_num),
        .B_num              (B_num),
        .operations_buttons (operations_buttons),
        .change_mode        (change_mode),
        .cmd_valid          (cmd_valid),
        .cmd_strobe         (cmd_strobe)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest expected capture.
    always @(negedge clk) begin
        if (rst_n && cmd_strobe) begin
            cmd_t got;
            cmd_t exp;
            strobes++;
            checks++;
            got = '{operations_buttons, change_mode, A_num, B_num};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got=%h required=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp || cmd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL capture got=%h valid=%b required=%h valid=1", got, cmd_valid, exp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] ops);
        exp_q.push_back('{ops, mode_sw, a_sw, b_sw});
    endtask

    task automatic wait_strobe(input int prev, input string name);
        for (int i = 0; i < 100 && strobes == prev; i++) @(posedge clk);
        #1;
        checks++;
        if (strobes == prev) begin
            errors++;
            $display("FAIL %s_timeout strobes=%0d required>%0d", name, strobes, prev);
        end
    endtask

    task automatic check_outputs(input string name, input logic [3:0] ops, input logic [1:0] mode,
                                 input logic [N-1:0] a, input logic [N-1:0] b, input logic valid);
        checks++;
        if (operations_buttons !== ops || change_mode !== mode || A_num !== a || B_num !== b ||
            cmd_valid !== valid) begin
            errors++;
            $display("FAIL %s got ops=%b mode=%b a=%h b=%h valid=%b required ops=%b mode=%b a=%h b=%h valid=%b",
                     name, operations_buttons, change_mode, A_num, B_num, cmd_valid, ops, mode, a, b, valid);
        end
    endtask

    // Counts posedges (input stable from edge 1) until strobe; expects edge 6 = k+1+D.
    task automatic measure_latency(input string name);
        int hit = 0;
        int s0  = strobes;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (cmd_strobe && hit == 0) hit = i;
        end
        checks++;
        if (hit !== 2 + D) begin
            errors++;
            $display("FAIL %s_latency got=%0d required=%0d", name, hit, 2 + D);
        end
        checks++;
        if (strobes - s0 !== 1) begin
            errors++;
            $display("FAIL %s_strobe_count got=%0d required=1", name, strobes - s0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; buttons_n = 4'b0000; mode_sw = 2'b00; a_sw = '0; b_sw = '0;
        cycles(5);
        check_outputs("reset", 4'b1111, 2'b00, 4'h0, 4'h0, 1'b0);
        checks++;
        if (cmd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe got=%b required=0", cmd_strobe);
        end
        buttons_n = 4'b1111;
        cycles(3);
        @(negedge clk) rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_clean_press();
        a_sw = 4'h5; b_sw = 4'h3; mode_sw = 2'b00;
        buttons_n = 4'b1110;
        push_cmd(4'b1110);
        measure_latency("clean");
        check_outputs("clean_captured", 4'b1110, 2'b00, 4'h5, 4'h3, 1'b1);
        cycles(10);
        buttons_n = 4'b1111;
        cycles(20);
        check_outputs("clean_after_release", 4'b1110, 2'b00, 4'h5, 4'h3, 1'b1);
    endtask

    task automatic test_bounce();
        int s0 = strobes;
        for (int t = 0; t < 3; t++) begin
            buttons_n = 4'b1101; cycles(2);
            buttons_n = 4'b1111; cycles(2);
        end
        checks++;
        if (strobes !== s0) begin
            errors++;
            $display("FAIL bounce_glitch_strobe got=%0d required=%0d", strobes - s0, 0);
        end
        push_cmd(4'b1101);
        buttons_n = 4'b1101;
        cycles(20);
        checks++;
        if (strobes - s0 !== 1) begin
            errors++;
            $display("FAIL bounce_strobe_count got=%0d required=1", strobes - s0);
        end
        check_outputs("bounce", 4'b1101, 2'b00, 4'h5, 4'h3, 1'b1);
        buttons_n = 4'b1111;
        cycles(20);
    endtask

    task automatic test_multi_press();
        int s0 = strobes;
        a_sw = 4'hA; b_sw = 4'hB;
        buttons_n = 4'b1100;
        cycles(50);
        checks++;
        if (strobes !== s0) begin
            errors++;
            $display("FAIL multi_strobe got=%0d required=0", strobes - s0);
        end
        check_outputs("multi_latch_kept", 4'b1101, 2'b00, 4'h5, 4'h3, 1'b1);
        buttons_n = 4'b1111;
        cycles(20);
    endtask

    task automatic test_hold();
        int s0;
        mode_sw = 2'b01; a_sw = 4'h9; b_sw = 4'hC;
        cycles(4);
        s0 = strobes;
        push_cmd(4'b0111);
        buttons_n = 4'b0111;
        wait_strobe(s0, "hold_first");
        a_sw = 4'h2; b_sw = 4'h7; mode_sw = 2'b10;
        cycles(20);
        check_outputs("hold_switch_change", 4'b0111, 2'b01, 4'h9, 4'hC, 1'b1);
        buttons_n = 4'b1111;
        cycles(20);
        check_outputs("hold_after_release", 4'b0111, 2'b01, 4'h9, 4'hC, 1'b1);
        s0 = strobes;
        push_cmd(4'b1011);
        buttons_n = 4'b1011;
        wait_strobe(s0, "hold_second");
        check_outputs("hold_second", 4'b1011, 2'b10, 4'h2, 4'h7, 1'b1);
        buttons_n = 4'b1111;
        cycles(20);
    endtask

    task automatic test_mid_reset();
        // Reset during ARM.
        buttons_n = 4'b1110;
        cycles(3);
        #2 rst_n = 1'b0;
        #1 check_outputs("reset_in_arm", 4'b1111, 2'b00, 4'h0, 4'h0, 1'b0);
        cycles(2);
        push_cmd(4'b1110);
        @(negedge clk) rst_n = 1'b1;
        measure_latency("rearm_after_arm_reset");
        check_outputs("recapture_arm", 4'b1110, 2'b10, 4'h2, 4'h7, 1'b1);
        // Reset during HOLD with the button still pressed.
        cycles(5);
        #2 rst_n = 1'b0;
        #1 check_outputs("reset_in_hold", 4'b1111, 2'b00, 4'h0, 4'h0, 1'b0);
        cycles(2);
        push_cmd(4'b1110);
        @(negedge clk) rst_n = 1'b1;
        measure_latency("rearm_after_hold_reset");
        buttons_n = 4'b1111;
        cycles(20);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_press();
        test_hold();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
